// File: rtl/keyword_tokenizer_if.sv
// Character-in / token-out bundle for keyword_tokenizer.
// The tokenizer takes the slave side; whatever feeds characters takes the master side.
interface keyword_tokenizer_if #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 16
);
    logic [7:0]       in_i;
    logic             in_valid_i;
    logic             flush_i;
    logic             tok_valid_o;
    logic [1:0]       tok_kind_o;
    logic [LEN_W-1:0] tok_len_o;
    logic [CNT_W-1:0] word_count_o;
    logic             busy_o;

    modport slave (
        input  in_i, in_valid_i, flush_i,
        output tok_valid_o, tok_kind_o, tok_len_o, word_count_o, busy_o
    );

    modport master (
        output in_i, in_valid_i, flush_i,
        input  tok_valid_o, tok_kind_o, tok_len_o, word_count_o, busy_o
    );
endinterface

// File: rtl/keyword_tokenizer.sv
// Splits an ASCII byte stream into words and emits one registered token per word,
// classified as BEGIN, END or OTHER (case-insensitive).
module keyword_tokenizer #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    keyword_tokenizer_if.slave   bus
);
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_OTH   = 4'd1,
        S_B     = 4'd2,
        S_BE    = 4'd3,
        S_BEG   = 4'd4,
        S_BEGI  = 4'd5,
        S_BEGIN = 4'd6,
        S_E     = 4'd7,
        S_EN    = 4'd8,
        S_END   = 4'd9
    } state_e;

    localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             tok_valid_q, tok_valid_d;
    logic [1:0]       tok_kind_q, tok_kind_d;
    logic [LEN_W-1:0] tok_len_q, tok_len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             letter_s, space_s, term_s;
    logic [7:0]       lower_s;
    state_e           st_after_s;
    logic [LEN_W-1:0] len_after_s;

    // Keyword prefix tracker: expects the next letter of "begin" or "end", otherwise OTH.
    function automatic state_e advance(input state_e st, input logic [7:0] lc);
        state_e nx;
        nx = S_OTH;
        case (st)
            S_IDLE: begin
                if (lc == 8'h62) begin
                    nx = S_B;
                end else if (lc == 8'h65) begin
                    nx = S_E;
                end else begin
                    nx = S_OTH;
                end
            end
            S_B:    nx = (lc == 8'h65) ? S_BE   : S_OTH;
            S_BE:   nx = (lc == 8'h67) ? S_BEG  : S_OTH;
            S_BEG:  nx = (lc == 8'h69) ? S_BEGI : S_OTH;
            S_BEGI: nx = (lc == 8'h6E) ? S_BEGIN : S_OTH;
            S_E:    nx = (lc == 8'h6E) ? S_EN   : S_OTH;
            S_EN:   nx = (lc == 8'h64) ? S_END  : S_OTH;
            default: nx = S_OTH;
        endcase
        return nx;
    endfunction

    function automatic logic [1:0] kind_of(input state_e st);
        logic [1:0] k;
        case (st)
            S_BEGIN: k = 2'b01;
            S_END:   k = 2'b10;
            default: k = 2'b00;
        endcase
        return k;
    endfunction

    // Apply the character first, then decide whether the (possibly extended) word terminates.
    always_comb begin
        letter_s    = 1'b0;
        space_s     = 1'b0;
        lower_s     = bus.in_i | 8'h20;
        st_after_s  = state_q;
        len_after_s = len_q;
        term_s      = 1'b0;
        state_d     = state_q;
        len_d       = len_q;
        tok_valid_d = 1'b0;
        tok_kind_d  = tok_kind_q;
        tok_len_d   = tok_len_q;
        cnt_d       = cnt_q;

        if (bus.in_valid_i) begin
            letter_s = ((bus.in_i >= 8'h41) && (bus.in_i <= 8'h5A)) ||
                       ((bus.in_i >= 8'h61) && (bus.in_i <= 8'h7A));
            space_s  = (bus.in_i == 8'h20);
        end else begin
            letter_s = 1'b0;
            space_s  = 1'b0;
        end

        if (letter_s) begin
            st_after_s  = advance(state_q, lower_s);
            len_after_s = (len_q == LEN_MAX) ? len_q : len_q + LEN_W'(1);
        end else begin
            st_after_s  = state_q;
            len_after_s = len_q;
        end

        term_s = (space_s || bus.flush_i) && (st_after_s != S_IDLE);

        if (term_s) begin
            state_d     = S_IDLE;
            len_d       = '0;
            tok_valid_d = 1'b1;
            tok_kind_d  = kind_of(st_after_s);
            tok_len_d   = len_after_s;
            cnt_d       = cnt_q + CNT_W'(1);
        end else begin
            state_d     = st_after_s;
            len_d       = len_after_s;
        end
    end

    // State, length and token registers; reset discards any open word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            tok_valid_q <= 1'b0;
            tok_kind_q  <= 2'b00;
            tok_len_q   <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            tok_valid_q <= tok_valid_d;
            tok_kind_q  <= tok_kind_d;
            tok_len_q   <= tok_len_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.tok_valid_o  = tok_valid_q;
    assign bus.tok_kind_o   = tok_kind_q;
    assign bus.tok_len_o    = tok_len_q;
    assign bus.word_count_o = cnt_q;
    assign bus.busy_o       = (state_q != S_IDLE);
endmodule

// File: tb/tb_keyword_tokenizer.sv
// Scoreboard bench for keyword_tokenizer: a word-level reference model queues expected
// tokens, and an independent monitor matches every tok_valid pulse against them.
module tb_keyword_tokenizer;
    localparam int LEN_W = 8;
    localparam int CNT_W = 16;
    localparam int LEN_SAT = (1 << LEN_W) - 1;

    typedef struct {
        logic [1:0]       kind;
        logic [LEN_W-1:0] len;
        logic [CNT_W-1:0] cnt;
        longint           due;
    } tok_t;

    logic   clk = 1'b0;
    logic   reset;
    longint cyc = 0;
    int     checks = 0;
    int     failures = 0;

    tok_t             exp_q[$];
    logic [7:0]       word_q[$];
    logic             exp_busy = 1'b0;
    logic [CNT_W-1:0] exp_cnt = '0;
    logic [1:0]       exp_kind = 2'b00;
    logic [LEN_W-1:0] exp_len = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    keyword_tokenizer_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();
    keyword_tokenizer #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit word_is(input logic [7:0] w[$], input string s);
        if (w.size() != s.len()) return 1'b0;
        foreach (w[i]) if (w[i] != s[i]) return 1'b0;
        return 1'b1;
    endfunction

    // One input cycle: check the visible state, drive the character, advance the word model.
    task automatic step(input logic v, input logic [7:0] c, input logic f);
        bit   letter, space;
        tok_t t;
        int   n;
        @(negedge clk);
        check("busy", bus.busy_o, exp_busy);
        check("word_count", bus.word_count_o, exp_cnt);
        check("tok_kind_hold", bus.tok_kind_o, exp_kind);
        check("tok_len_hold", bus.tok_len_o, exp_len);
        bus.in_i       = c;
        bus.in_valid_i = v;
        bus.flush_i    = f;
        letter = v && (((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A)));
        space  = v && (c == 8'h20);
        if (letter) word_q.push_back(c | 8'h20);
        if ((space || f) && (word_q.size() > 0)) begin
            n      = word_q.size();
            t.kind = word_is(word_q, "begin") ? 2'b01 : (word_is(word_q, "end") ? 2'b10 : 2'b00);
            t.len  = LEN_W'((n > LEN_SAT) ? LEN_SAT : n);
            exp_cnt = exp_cnt + 1'b1;
            t.cnt  = exp_cnt;
            t.due  = cyc + 1;
            exp_q.push_back(t);
            exp_kind = t.kind;
            exp_len  = t.len;
            word_q.delete();
        end
        exp_busy = (word_q.size() > 0);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) step(1'b1, 8'(s[i]), 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        bus.flush_i    = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_tok_valid", bus.tok_valid_o, 0);
        check("rst_word_count", bus.word_count_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_tok_kind", bus.tok_kind_o, 0);
        check("rst_tok_len", bus.tok_len_o, 0);
        word_q.delete();
        exp_q.delete();
        exp_busy = 1'b0;
        exp_cnt  = '0;
        exp_kind = 2'b00;
        exp_len  = '0;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Monitor: every token must match the head of the queue and arrive exactly when due.
    initial begin
        tok_t t;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.tok_valid_o) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_token", bus.tok_valid_o, 0);
                    end else begin
                        t = exp_q.pop_front();
                        check("tok_kind", bus.tok_kind_o, t.kind);
                        check("tok_len", bus.tok_len_o, t.len);
                        check("tok_count", bus.word_count_o, t.cnt);
                        check("tok_latency", cyc, t.due);
                    end
                end else if ((exp_q.size() > 0) && (exp_q[0].due < cyc)) begin
                    check("missing_token", bus.tok_valid_o, 1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        string      words[15];
        string      w;
        logic [7:0] c;
        logic [7:0] noise[6];
        words = '{"begin", "end", "b", "be", "beg", "begi", "e", "en", "beginx",
                  "endx", "xbegin", "ab", "zzzz", "bend", "ende"};
        noise = '{8'h21, 8'h31, 8'h40, 8'h5B, 8'h60, 8'h7B};
        reset          = 1'b1;
        bus.in_i       = 8'h00;
        bus.in_valid_i = 1'b0;
        bus.flush_i    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("init_tok_valid", bus.tok_valid_o, 0);
        check("init_word_count", bus.word_count_o, 0);
        check("init_busy", bus.busy_o, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        send_str("Begin eNd ");
        send_str("beginx en ");
        send_str("begi");
        step(1'b0, 8'h00, 1'b1);
        send_str("be!g1in ");
        send_str("   ");
        send_str("en");
        step(1'b1, 8'h64, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h21, 1'b1);
        step(1'b1, 8'h45, 1'b1);
        idle(2);
        send_str("begi");
        pulse_reset();
        send_str("end ");
        idle(2);

        // Long word must saturate the length field.
        for (int i = 0; i < LEN_SAT + 45; i++) step(1'b1, ($urandom_range(0, 1) != 0) ? 8'h41 : 8'h61, 1'b0);
        send_str(" ");

        // Random words with random case, interleaved noise and mixed terminators.
        for (int k = 0; k < 400; k++) begin
            w = words[$urandom_range(0, 14)];
            for (int i = 0; i < w.len(); i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) != 0) step(1'b0, 8'(s_rand()), 1'b0);
                    else step(1'b1, noise[$urandom_range(0, 5)], 1'b0);
                end
                c = 8'(w[i]);
                if ($urandom_range(0, 1) != 0) c = c & 8'hDF;
                if ((i == w.len() - 1) && ($urandom_range(0, 3) == 0)) step(1'b1, c, 1'b1);
                else step(1'b1, c, 1'b0);
            end
            case ($urandom_range(0, 3))
                0: step(1'b0, 8'h00, 1'b1);
                1: step(1'b1, noise[$urandom_range(0, 5)], 1'b1);
                2: step(1'b1, 8'h20, 1'b1);
                default: for (int j = 0; j < $urandom_range(1, 3); j++) send_str(" ");
            endcase
        end

        idle(4);
        check("tokens_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic int s_rand();
        return int'($urandom_range(0, 255));
    endfunction
endmodule
